// File: rtl/uart_pkg.sv
// uart_pkg: state encodings, parity constants and parity helper shared by uart_core
package uart_pkg;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  localparam int MAX_D_W = 9;
  function automatic logic parity_bit(input logic [MAX_D_W-1:0] data, input logic odd);
    return (^data) ^ (odd == PAR_ODD);
  endfunction
endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: free-running oversampling tick, one pulse every divisor+1 clk cycles
module uart_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == divisor;
    cnt_d = cnt_q >= divisor ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    cnt_q <= rst ? cnt_d : '0;
  end
endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex UART engine (tick gen, TX serializer, RX deserializer); UART_LOOPBACK_EN adds the loopback port
module uart_core
  import uart_pkg::*;
#(
  parameter int D_W = 8,
  parameter int B_TICK = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             two_stop,
  input  logic [D_W-1:0]   tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             txd,
  output logic             tx_busy,
  input  logic             rxd,
  output logic [D_W-1:0]   rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic             rx_overrun
`ifdef UART_LOOPBACK_EN
  ,
  input  logic             loopback
`endif
);
  localparam int BW = $clog2(D_W);
  localparam int TW = $clog2(B_TICK);
  localparam logic [BW-1:0] BIT_LAST = BW'(D_W - 1);
  localparam logic [TW-1:0] TK_LAST = TW'(B_TICK - 1);
  localparam logic [TW-1:0] TK_HALF = TW'(B_TICK / 2 - 1);
  logic tick, tx_bit, tx_end, rx_in, rx_half, rx_end, rx_done, rx_take, rx_load, lb_q;
  tx_state_e tx_st_q, tx_st_d;
  rx_state_e rx_st_q, rx_st_d;
  logic [TW-1:0] tx_tk_q, tx_tk_d, rx_tk_q, rx_tk_d;
  logic [BW-1:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [D_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic tx_pen_q, tx_pen_d, tx_par_q, tx_par_d, tx_two_q, tx_two_d, tx_stop2_q, tx_stop2_d;
  logic rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d, rx_perr_q, rx_perr_d;
  logic sync1_q, sync1_d, sync2_q, sync2_d;
  logic rx_valid_q, rx_valid_d, rx_parity_err_q, rx_parity_err_d;
  logic rx_frame_err_q, rx_frame_err_d, rx_overrun_q, rx_overrun_d;
  uart_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk(clk),
    .rst(rst),
    .divisor(divisor),
    .tick(tick)
  );
`ifdef UART_LOOPBACK_EN
  logic lb_d;
  always_comb begin
    lb_d = (tx_st_q == TX_IDLE && rx_st_q == RX_IDLE) ? loopback : lb_q;
  end
  always_ff @(posedge clk) begin
    lb_q <= rst ? lb_d : 1'b0;
  end
`else
  assign lb_q = 1'b0;
`endif
  always_comb begin
    tx_ready = tx_st_q == TX_IDLE && rst;
    tx_busy = tx_st_q != TX_IDLE;
    tx_end = tick && tx_tk_q == TK_LAST;
    tx_st_d = tx_st_q;
    tx_tk_d = tx_end ? '0 : tx_tk_q + TW'(tick);
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_pen_d = tx_pen_q;
    tx_par_d = tx_par_q;
    tx_two_d = tx_two_q;
    tx_stop2_d = tx_stop2_q;
    case (tx_st_q)
      TX_IDLE: if (tx_valid && tx_ready) begin
        tx_st_d = TX_START;
        tx_tk_d = '0;
        tx_sh_d = tx_data;
        tx_pen_d = parity_en;
        tx_par_d = parity_bit(MAX_D_W'(tx_data), parity_odd);
        tx_two_d = two_stop;
        tx_stop2_d = 1'b0;
      end
      TX_START: if (tx_end) begin
        tx_st_d = TX_DATA;
        tx_bit_d = '0;
      end
      TX_DATA: if (tx_end) begin
        tx_sh_d = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 1'b1;
        if (tx_bit_q == BIT_LAST) tx_st_d = tx_pen_q ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: if (tx_end) tx_st_d = TX_STOP;
      TX_STOP: if (tx_end) begin
        tx_stop2_d = 1'b1;
        tx_st_d = (tx_two_q && !tx_stop2_q) ? TX_STOP : TX_IDLE;
      end
      default: tx_st_d = TX_IDLE;
    endcase
    tx_bit = tx_st_q == TX_START ? 1'b0 : tx_st_q == TX_DATA ? tx_sh_q[0] :
             tx_st_q == TX_PARITY ? tx_par_q : 1'b1;
    txd = tx_bit | lb_q;
  end
  always_comb begin
    sync1_d = lb_q ? tx_bit : rxd;
    sync2_d = sync1_q;
    rx_in = sync2_q;
    rx_half = tick && rx_tk_q == TK_HALF;
    rx_end = tick && rx_tk_q == TK_LAST;
    rx_done = 1'b0;
    rx_st_d = rx_st_q;
    rx_tk_d = rx_tk_q + TW'(tick);
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_pen_d = rx_pen_q;
    rx_odd_d = rx_odd_q;
    rx_perr_d = rx_perr_q;
    case (rx_st_q)
      RX_IDLE: if (!rx_in) begin
        rx_st_d = RX_START;
        rx_tk_d = '0;
        rx_pen_d = parity_en;
        rx_odd_d = parity_odd;
        rx_perr_d = 1'b0;
      end
      RX_START: if (rx_half) begin
        rx_st_d = rx_in ? RX_IDLE : RX_DATA;
        rx_tk_d = '0;
        rx_bit_d = '0;
      end
      RX_DATA: if (rx_end) begin
        rx_tk_d = '0;
        rx_sh_d = {rx_in, rx_sh_q[D_W-1:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        if (rx_bit_q == BIT_LAST) rx_st_d = rx_pen_q ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_end) begin
        rx_tk_d = '0;
        rx_perr_d = rx_in != parity_bit(MAX_D_W'(rx_sh_q), rx_odd_q);
        rx_st_d = RX_STOP;
      end
      RX_STOP: if (rx_end) begin
        rx_done = 1'b1;
        rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
    rx_take = rx_valid_q && rx_ready;
    rx_load = rx_done && (!rx_valid_q || rx_take);
    rx_valid_d = rx_load || (rx_valid_q && !rx_take);
    rx_data_d = rx_load ? rx_sh_q : rx_data_q;
    rx_parity_err_d = rx_load ? rx_perr_q : rx_parity_err_q;
    rx_frame_err_d = rx_load ? !rx_in : rx_frame_err_q;
    rx_overrun_d = rx_done && rx_valid_q && !rx_take;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_st_q <= TX_IDLE;
      tx_tk_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      tx_pen_q <= 1'b0;
      tx_par_q <= 1'b0;
      tx_two_q <= 1'b0;
      tx_stop2_q <= 1'b0;
      rx_st_q <= RX_IDLE;
      rx_tk_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_pen_q <= 1'b0;
      rx_odd_q <= PAR_EVEN;
      rx_perr_q <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      tx_st_q <= tx_st_d;
      tx_tk_q <= tx_tk_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      tx_pen_q <= tx_pen_d;
      tx_par_q <= tx_par_d;
      tx_two_q <= tx_two_d;
      tx_stop2_q <= tx_stop2_d;
      rx_st_q <= rx_st_d;
      rx_tk_q <= rx_tk_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      rx_pen_q <= rx_pen_d;
      rx_odd_q <= rx_odd_d;
      rx_perr_q <= rx_perr_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_parity_err_q <= rx_parity_err_d;
      rx_frame_err_q <= rx_frame_err_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_parity_err = rx_parity_err_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_overrun = rx_overrun_q;
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: scoreboard bench for uart_core framing, parity, frame error, overrun, false start, reset and loopback
module tb_uart_core;
  localparam int D_W = 8;
  localparam int B_TICK = 16;
  localparam int DIV_W = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [DIV_W-1:0] divisor;
  logic parity_en, parity_odd, two_stop, tx_valid, tx_ready, txd, tx_busy, rxd;
  logic [D_W-1:0] tx_data, rx_data;
  logic rx_valid, rx_ready, rx_parity_err, rx_frame_err, rx_overrun;
  logic lb_ext = 1'b0;
  logic rxd_drv = 1'b1;
  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  logic [D_W+1:0] exp_q[$];
`ifdef UART_LOOPBACK_EN
  logic loopback = 1'b0;
`endif
  uart_core #(.D_W(D_W), .B_TICK(B_TICK), .DIV_W(DIV_W)) dut (
    .clk(clk),
    .rst(rst),
    .divisor(divisor),
    .parity_en(parity_en),
    .parity_odd(parity_odd),
    .two_stop(two_stop),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .txd(txd),
    .tx_busy(tx_busy),
    .rxd(rxd),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err),
    .rx_overrun(rx_overrun)
`ifdef UART_LOOPBACK_EN
    ,
    .loopback(loopback)
`endif
  );
  always #5 clk = ~clk;
  assign rxd = lb_ext ? txd : rxd_drv;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] frame_bits(input logic [D_W-1:0] d, input logic pen, input logic odd);
    logic [15:0] b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < D_W; i++) b[i+1] = d[i];
    if (pen) b[D_W+1] = (^d) ^ odd;
    return b;
  endfunction
  always @(negedge clk) begin
    if (rx_overrun === 1'b1) ovr_cnt++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      if (exp_q.size() == 0) check("rx_unexpected_valid", rx_valid, 0);
      else check("rx_frame", {rx_frame_err, rx_parity_err, rx_data}, exp_q.pop_front());
    end
  end
  task automatic send_tx(input string tag, input logic [D_W-1:0] d, input logic pen, input logic odd,
                         input logic two, input logic rx_odd);
    int nb = 2 + D_W + int'(pen) + int'(two);
    logic [15:0] b = frame_bits(d, pen, odd);
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    parity_en = pen;
    parity_odd = odd;
    two_stop = two;
    check({tag, "_ready_pre"}, tx_ready, 1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    parity_odd = rx_odd;
    for (int c = 0; c < nb * B_TICK; c++) begin
      @(negedge clk);
      if (c % B_TICK == B_TICK / 2) check({tag, "_txd"}, txd, b[c/B_TICK]);
      if (c == 0 || c == nb * B_TICK - 1) check({tag, "_busy_ready"}, {tx_busy, tx_ready}, 2'b10);
    end
    @(negedge clk);
    check({tag, "_ready_post"}, {tx_busy, tx_ready}, 2'b01);
  endtask
  task automatic drive_rx(input logic [D_W-1:0] d, input logic stop);
    logic [D_W+1:0] b = {stop, d, 1'b0};
    for (int i = 0; i < D_W + 2; i++) begin
      @(negedge clk);
      rxd_drv = b[i];
      repeat (B_TICK - 1) @(negedge clk);
    end
    @(negedge clk);
    rxd_drv = 1'b1;
    repeat (3 * B_TICK) @(negedge clk);
  endtask
  task automatic wait_rx(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rx_drained"}, exp_q.size(), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    divisor = '0;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    two_stop = 1'b0;
    tx_data = '0;
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", txd, 1);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send_tx("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    send_tx("two_stop", 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    lb_ext = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 8'h07});
    send_tx("par_err", 8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_rx("par_err", 100);
    exp_q.push_back({1'b0, 1'b0, 8'hC3});
    send_tx("par_odd", 8'hC3, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_rx("par_odd", 100);
    @(negedge clk);
    lb_ext = 1'b0;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    repeat (B_TICK) @(negedge clk);
    exp_q.push_back({1'b1, 1'b0, 8'h3C});
    drive_rx(8'h3C, 1'b0);
    wait_rx("frame_err", 100);
    exp_q.push_back({1'b0, 1'b0, 8'h96});
    drive_rx(8'h96, 1'b1);
    wait_rx("good_frame", 100);
    @(negedge clk);
    rx_ready = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 8'h11});
    drive_rx(8'h11, 1'b1);
    drive_rx(8'h22, 1'b1);
    check("ovr_pulses", ovr_cnt, 1);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h11);
    rx_ready = 1'b1;
    wait_rx("ovr", 20);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (3 * B_TICK) @(negedge clk);
    check("false_start_valid", rx_valid, 0);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (3 * B_TICK) @(negedge clk);
    check("rst_mid_txd_pre", {tx_busy, txd}, 2'b10);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_txd", txd, 1);
    check("rst_mid_ready_low", {tx_busy, tx_ready}, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_ready_high", tx_ready, 1);
`ifdef UART_LOOPBACK_EN
    @(negedge clk);
    divisor = 16'd3;
    loopback = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back({1'b0, 1'b0, 8'h5A});
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (c % 32 == 0) check("lb_txd_high", txd, 1);
    end
    wait_rx("loopback", 400);
    loopback = 1'b0;
    divisor = '0;
`endif
    repeat (4) @(negedge clk);
    check("ovr_total", ovr_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Parametrised, full-duplex UART serial engine: shared oversampling tick generator, TX serializer, RX deserializer.
- Data width, oversampling rate, parity and stop-bit count are configurable.
- Sits between the existing rx/tx `fifo` instances and the pins.
- Valid/ready handshakes on both sides map directly onto FIFO rd/wr enables.

Parameters:
- D_W, 8, data bits per frame (5..9).
- B_TICK, 16, oversampling ticks per bit (even, >=4).
- DIV_W, 16, width of the baud divisor.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- divisor  in  DIV_W  tick period minus one, in clk cycles.
- parity_en  in  1  1 = parity bit present.
- parity_odd  in  1  1 = odd parity, 0 = even.
- two_stop  in  1  1 = TX sends two stop bits.
- tx_data  in  D_W  byte to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  serializer idle, accepts tx_data.
- txd  out  1  serial output, idle high.
- tx_busy  out  1  frame in progress.
- rxd  in  1  asynchronous serial input.
- rx_data  out  D_W  received byte.
- rx_valid  out  1  rx_data and error flags valid.
- rx_ready  in  1  consumer accepts rx_data.
- rx_parity_err  out  1  parity mismatch on the held byte.
- rx_frame_err  out  1  stop bit sampled low on the held byte.
- rx_overrun  out  1  one-cycle pulse: frame completed while rx_valid was high.

Behaviour:
- Reset (rst==0 at a clk edge) values:
  - txd=1; all other outputs 0, including tx_ready.
  - Both FSMs to IDLE, tick counter 0, rxd synchronizer flops 1.
  - Reset mid-frame aborts the frame immediately; txd is 1 on the first cycle after the reset edge.
- Tick generator:
  - Counter 0..divisor; `tick` pulses for one cycle when count==divisor, then count returns to 0.
  - Tick period = divisor+1 cycles; divisor=0 gives a tick every cycle.
  - Free-running, shared by TX and RX.
  - A divisor change takes effect at the next wrap; if count>divisor, count wraps to 0 next cycle without a tick.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - tx_ready = (state==IDLE) && rst.
  - Accept on tx_valid&&tx_ready: latch tx_data, parity_en, parity_odd, two_stop; go to START.
  - txd=0 from the following cycle.
  - Each bit lasts B_TICK ticks. The first bit may also include up to divisor cycles of phase slack.
  - DATA shifts LSB first for D_W bits.
  - PARITY is entered only if parity_en. Parity bit = XOR(data) ^ parity_odd.
  - STOP lasts 1 or 2 bit times, then returns to IDLE; tx_ready is high the next cycle.
  - tx_busy = !IDLE.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - Input path: 2-flop synchronizer on rxd.
  - IDLE: synchronized rxd==0 → START; reset the sample tick count and latch the parity config.
  - START: after B_TICK/2 ticks, resample. If 1 (false start) → IDLE with no output; else → DATA.
  - DATA, PARITY, STOP: sample every B_TICK ticks, i.e. mid-bit. DATA is LSB first.
  - Only the first stop bit is checked.
- RX completion, on the STOP sample:
  - If rx_valid==0: load rx_data, rx_parity_err, rx_frame_err; set rx_valid.
  - If rx_valid==1: drop the new frame, keep the old data, pulse rx_overrun for one cycle.
  - rx_valid clears on rx_valid&&rx_ready.
  - If completion and consume happen in the same cycle: load the new frame, keep rx_valid=1, no overrun.
  - RX returns to IDLE after the STOP sample and accepts a new start edge immediately.
- Width rules:
  - Bit counter is $clog2(D_W) bits wide.
  - Oversample counter is $clog2(B_TICK) bits wide.
  - No truncation on divisor compare.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined:
  - Extra input port `loopback` (1 bit).
  - When loopback==1: the RX synchronizer input is the internal TX serial bit, and txd is forced to 1.
  - The loopback value is sampled only while both FSMs are IDLE; changes mid-frame are deferred until both are IDLE.
- Undefined: port absent, RX always uses rxd.

Decomposition:
- Package uart_pkg holds:
  - TX/RX state enums (3-bit encodings).
  - Parity-mode constants.
  - A function computing the parity bit.
- One sub-module, uart_tick_gen (divisor counter, tick output), instantiated once in uart_core.
- TX and RX FSMs stay inline.

Test Plan:
- TX framing: D_W=8, B_TICK=16, divisor=0, no parity, 1 stop; send 0xA5 → txd=0,1,0,1,0,0,1,0,1,1, each 16 cycles; tx_ready low 160 cycles, then high.
- Parity: parity_en=1, parity_odd=0, send 0x07 → parity bit 1. Loop back with parity_odd=1 into RX → rx_parity_err=1, rx_data=0x07.
- Frame error: drive rxd 0x3C with stop bit held 0 → rx_valid=1, rx_data=0x3C, rx_frame_err=1.
- Overrun: rx_ready=0; receive 0x11 then 0x22 → rx_data stays 0x11, one rx_overrun pulse after the second stop sample.
- False start and reset:
  - rxd low for 4 cycles with divisor=0 → no rx_valid.
  - Assert rst during DATA of a TX frame → txd=1 next cycle; tx_ready=1 one cycle after release.
- Loopback (macro on): loopback=1, send 0x5A, divisor=3 → rx_valid with 0x5A; txd stays 1 throughout.
